// File: rtl/regsel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regsel_sequencer_pkg
//  Purpose  : Opcodes, regSel source encodings, state encoding and the
//             control-word type shared by the regSel sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package regsel_sequencer_pkg;

    localparam logic [1:0] OP_MOV   = 2'b00;
    localparam logic [1:0] OP_ALU2  = 2'b01;
    localparam logic [1:0] OP_ALU1  = 2'b10;
    localparam logic [1:0] OP_PCINC = 2'b11;

    localparam logic [1:0] SRC_USEQ = 2'd0;
    localparam logic [1:0] SRC_OP0  = 2'd1;
    localparam logic [1:0] SRC_OP1  = 2'd2;
    localparam logic [1:0] SRC_OP2  = 2'd3;
    localparam logic       LSRC_USEQ = 1'b0;
    localparam logic       LSRC_OP0  = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD_A = 2'd1;
    localparam logic [1:0] ST_RD_B = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RD_A = ST_RD_A,
        RD_B = ST_RD_B,
        WR   = ST_WR
    } state_t;

    typedef struct packed {
        logic       oe;
        logic       load;
        logic [1:0] oeSourceSel;
        logic       loadSourceSel;
        logic [2:0] useqRegSelOE;
        logic [2:0] useqRegSelLoad;
        logic       aluALoad;
        logic       aluBLoad;
        logic       aluOE;
        logic       aluInc;
        logic       ready;
        logic       done;
    } ctrl_t;

    // MOV needs no operand fetch, so it enters straight at the write phase.
    function automatic state_t entryState(input logic [1:0] op);
        return (op == OP_MOV) ? WR : RD_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regsel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regsel_sequencer
//  Purpose  : Steps one register-transfer operation at a time through the
//             regSel / ALU-latch bus phases; all outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module regsel_sequencer
    import regsel_sequencer_pkg::*;
#(
    parameter logic [2:0] PC_REG   = 3'd7,
    parameter int         WIDTH_OP = 2
) (
    input  logic                clock,
    input  logic                notReset,
    input  logic                start,
    input  logic [WIDTH_OP-1:0] opcode,
    input  logic                stall,
    output logic                oe,
    output logic                load,
    output logic [1:0]          oeSourceSel,
    output logic                loadSourceSel,
    output logic [2:0]          useqRegSelOE,
    output logic [2:0]          useqRegSelLoad,
    output logic                aluALoad,
    output logic                aluBLoad,
    output logic                aluOE,
    output logic                aluInc,
    output logic                ready,
    output logic                done
);

    state_t              r_state;
    logic [WIDTH_OP-1:0] r_op;
    ctrl_t               r_ctrl;
    state_t              w_nextState;
    logic [WIDTH_OP-1:0] w_nextOp;

    function automatic ctrl_t decode(input state_t st, input logic [1:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            IDLE: c.ready = 1'b1;
            RD_A: begin
                c.oe       = 1'b1;
                c.aluALoad = 1'b1;
                if (op == OP_PCINC) begin
                    c.oeSourceSel  = SRC_USEQ;
                    c.useqRegSelOE = PC_REG;
                end else begin
                    c.oeSourceSel = SRC_OP1;
                end
            end
            RD_B: begin
                c.oe          = 1'b1;
                c.oeSourceSel = SRC_OP2;
                c.aluBLoad    = 1'b1;
            end
            WR: begin
                c.load  = 1'b1;
                c.ready = 1'b1;
                c.done  = 1'b1;
                case (op)
                    OP_MOV: begin
                        c.oe            = 1'b1;
                        c.oeSourceSel   = SRC_OP1;
                        c.loadSourceSel = LSRC_OP0;
                    end
                    OP_PCINC: begin
                        c.aluOE          = 1'b1;
                        c.aluInc         = 1'b1;
                        c.loadSourceSel  = LSRC_USEQ;
                        c.useqRegSelLoad = PC_REG;
                    end
                    default: begin
                        c.aluOE         = 1'b1;
                        c.loadSourceSel = LSRC_OP0;
                    end
                endcase
            end
            default: c.ready = 1'b1;
        endcase
        return c;
    endfunction

    // A new request is only accepted in a ready state (IDLE or final WR).
    always_comb begin
        w_nextState = r_state;
        w_nextOp    = r_op;
        case (r_state)
            IDLE, WR: begin
                if (start) begin
                    w_nextOp    = opcode;
                    w_nextState = entryState(opcode);
                end else begin
                    w_nextState = IDLE;
                end
            end
            RD_A:    w_nextState = (r_op == OP_ALU2) ? RD_B : WR;
            RD_B:    w_nextState = WR;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_state <= IDLE;
            r_op    <= OP_MOV;
            r_ctrl  <= decode(IDLE, OP_MOV);
        end else if (!stall) begin
            r_state <= w_nextState;
            r_op    <= w_nextOp;
            r_ctrl  <= decode(w_nextState, w_nextOp);
        end
    end

    assign oe             = r_ctrl.oe;
    assign load           = r_ctrl.load;
    assign oeSourceSel    = r_ctrl.oeSourceSel;
    assign loadSourceSel  = r_ctrl.loadSourceSel;
    assign useqRegSelOE   = r_ctrl.useqRegSelOE;
    assign useqRegSelLoad = r_ctrl.useqRegSelLoad;
    assign aluALoad       = r_ctrl.aluALoad;
    assign aluBLoad       = r_ctrl.aluBLoad;
    assign aluOE          = r_ctrl.aluOE;
    assign aluInc         = r_ctrl.aluInc;
    assign ready          = r_ctrl.ready;
    assign done           = r_ctrl.done;

endmodule
`default_nettype wire

// File: tb/tb_regsel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regsel_sequencer
//  Purpose  : Directed bench for regsel_sequencer against a phase-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regsel_sequencer;

    logic       clock = 1'b0;
    logic       notReset;
    logic       start;
    logic [1:0] opcode;
    logic       stall;
    logic       oe, load, loadSourceSel, aluALoad, aluBLoad, aluOE, aluInc, ready, done;
    logic [1:0] oeSourceSel;
    logic [2:0] useqRegSelOE, useqRegSelLoad;

    int errors = 0;
    int checks = 0;

    regsel_sequencer #(.PC_REG(3'd7), .WIDTH_OP(2)) dut (
        .clock(clock), .notReset(notReset), .start(start), .opcode(opcode), .stall(stall),
        .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOE(useqRegSelOE), .useqRegSelLoad(useqRegSelLoad),
        .aluALoad(aluALoad), .aluBLoad(aluBLoad), .aluOE(aluOE), .aluInc(aluInc),
        .ready(ready), .done(done)
    );

    always #5 clock = ~clock;

    logic [16:0] dutVec;
    assign dutVec = {oe, load, oeSourceSel, loadSourceSel, useqRegSelOE, useqRegSelLoad,
                     aluALoad, aluBLoad, aluOE, aluInc, ready, done};

    localparam logic [16:0] IDLE_VEC = 17'h00002;

    // One bus phase; the last phase of an operation carries ready and done.
    function automatic logic [16:0] ph(input logic o, input logic l, input logic [1:0] os,
                                       input logic ls, input logic [2:0] uo, input logic [2:0] ul,
                                       input logic a, input logic b, input logic ao,
                                       input logic inc, input logic last);
        return {o, l, os, ls, uo, ul, a, b, ao, inc, last, last};
    endfunction

    // Model: an operation is a list of phases consumed one per unstalled cycle.
    logic [16:0] mCur;
    logic [16:0] mQ[$];
    always @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            mCur = IDLE_VEC;
            mQ.delete();
        end else if (!stall) begin
            if (mCur[1] && start) begin
                mQ.delete();
                case (opcode)
                    2'b00: mQ.push_back(ph(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1));
                    2'b01: begin
                        mQ.push_back(ph(1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0));
                        mQ.push_back(ph(1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
                        mQ.push_back(ph(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
                    end
                    2'b10: begin
                        mQ.push_back(ph(1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0));
                        mQ.push_back(ph(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1));
                    end
                    default: begin
                        mQ.push_back(ph(1, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0));
                        mQ.push_back(ph(0, 1, 0, 0, 0, 7, 0, 0, 1, 1, 1));
                    end
                endcase
            end
            if (mQ.size() > 0) mCur = mQ.pop_front();
            else               mCur = IDLE_VEC;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, step one rising edge, compare at the next falling edge.
    task automatic cyc(input logic s, input logic [1:0] op, input logic st);
        start  = s;
        opcode = op;
        stall  = st;
        @(posedge clock);
        @(negedge clock);
        chk("model", {15'd0, dutVec}, {15'd0, mCur});
        chk("no_bus_contention", {31'd0, oe & aluOE}, 32'd0);
        chk("load_only_in_wr", {31'd0, load & ~done}, 32'd0);
    endtask

    int lat;
    int doneCnt;
    int expLat[4] = '{1, 3, 2, 2};

    initial begin
        notReset = 1'b0;
        start    = 1'b0;
        opcode   = 2'b00;
        stall    = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_vec", {15'd0, dutVec}, {15'd0, IDLE_VEC});
        notReset = 1'b1;
        cyc(0, 0, 0);

        // MOV
        cyc(1, 2'b00, 0);
        chk("mov_oe", {31'd0, oe}, 1);
        chk("mov_oesrc", {30'd0, oeSourceSel}, 2);
        chk("mov_load", {31'd0, load}, 1);
        chk("mov_lsrc", {31'd0, loadSourceSel}, 1);
        chk("mov_done", {31'd0, done}, 1);
        cyc(0, 0, 0);
        chk("mov_idle_done", {31'd0, done}, 0);

        // ALU2
        cyc(1, 2'b01, 0);
        chk("alu2_c1_aload", {31'd0, aluALoad}, 1);
        chk("alu2_c1_oesrc", {30'd0, oeSourceSel}, 2);
        chk("alu2_c1_ready", {31'd0, ready}, 0);
        cyc(0, 0, 0);
        chk("alu2_c2_bload", {31'd0, aluBLoad}, 1);
        chk("alu2_c2_oesrc", {30'd0, oeSourceSel}, 3);
        cyc(0, 0, 0);
        chk("alu2_c3_aluoe", {31'd0, aluOE}, 1);
        chk("alu2_c3_oe", {31'd0, oe}, 0);
        chk("alu2_c3_load", {31'd0, load}, 1);
        chk("alu2_c3_lsrc", {31'd0, loadSourceSel}, 1);
        chk("alu2_c3_done", {31'd0, done}, 1);
        cyc(0, 0, 0);

        // PCINC
        cyc(1, 2'b11, 0);
        chk("pc_rda_useqoe", {29'd0, useqRegSelOE}, 7);
        chk("pc_rda_oesrc", {30'd0, oeSourceSel}, 0);
        cyc(0, 0, 0);
        chk("pc_wr_inc", {31'd0, aluInc}, 1);
        chk("pc_wr_useqld", {29'd0, useqRegSelLoad}, 7);
        chk("pc_wr_lsrc", {31'd0, loadSourceSel}, 0);
        chk("pc_wr_done", {31'd0, done}, 1);
        cyc(0, 0, 0);

        // Back-to-back ALU1 then MOV with start held high
        doneCnt = 0;
        cyc(1, 2'b10, 0); doneCnt += int'(done);
        cyc(1, 2'b00, 0); doneCnt += int'(done);
        cyc(1, 2'b00, 0); doneCnt += int'(done);
        chk("b2b_mov_oe", {31'd0, oe}, 1);
        chk("b2b_done_count", doneCnt, 2);
        cyc(0, 0, 0);

        // ALU2 with stall in RD_B and ignored starts while busy
        cyc(1, 2'b01, 0); lat = 1;
        cyc(1, 2'b11, 0); lat++;
        chk("stall_in_rdb", {31'd0, aluBLoad}, 1);
        cyc(0, 0, 1); lat++;
        cyc(1, 2'b00, 1); lat++;
        chk("stall_frozen_bload", {31'd0, aluBLoad}, 1);
        chk("stall_no_done", {31'd0, done}, 0);
        cyc(0, 0, 0); lat++;
        chk("stall_done", {31'd0, done}, 1);
        chk("stall_latency", lat, 5);
        cyc(1, 2'b00, 1);
        chk("stall_wr_done_held", {31'd0, done}, 1);
        chk("stall_wr_aluoe", {31'd0, aluOE}, 1);
        cyc(0, 0, 0);
        chk("after_stall_idle", {15'd0, dutVec}, {15'd0, IDLE_VEC});

        // Start-to-done latency per opcode
        for (int op = 0; op < 4; op++) begin
            cyc(1, 2'(op), 0);
            lat = 1;
            while (!done && lat < 10) begin
                cyc(0, 0, 0);
                lat++;
            end
            chk($sformatf("latency_op%0d", op), lat, expLat[op]);
            cyc(0, 0, 0);
        end

        // Mixed stream compared against the model every cycle
        for (int i = 0; i < 40; i++) begin
            cyc(((i % 3) != 1) ? 1'b1 : 1'b0, 2'((i * 3 + i / 4) % 4), ((i % 7) == 3) ? 1'b1 : 1'b0);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Asynchronous reset in RD_B of ALU2
        cyc(1, 2'b01, 0);
        cyc(0, 0, 0);
        chk("pre_reset_rdb", {31'd0, aluBLoad}, 1);
        #2 notReset = 1'b0;
        #1;
        chk("async_reset_vec", {15'd0, dutVec}, {15'd0, IDLE_VEC});
        @(negedge clock);
        notReset = 1'b1;
        cyc(0, 0, 0);
        chk("post_reset_idle", {15'd0, dutVec}, {15'd0, IDLE_VEC});
        cyc(1, 2'b00, 0);
        chk("post_reset_mov_done", {31'd0, done}, 1);
        cyc(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
